// File: rtl/irrigation_pkg.sv
// Shared types and the tank-probe decode for the irrigation scheduler.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package irrigation_pkg;

    typedef enum logic [1:0] {
        LVL_EMPTY = 2'b00,
        LVL_LOW   = 2'b01,
        LVL_MED   = 2'b10,
        LVL_FULL  = 2'b11
    } level_t;

    typedef enum logic {
        MODE_DRIP      = 1'b0,
        MODE_SPRINKLER = 1'b1
    } mode_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_WATER = 2'b01,
        ST_GAP   = 2'b10
    } state_t;

    // Probes are ordered {H,M,L}; water can only cover a probe if every lower one is wet.
    function automatic logic level_valid(input logic [2:0] hml);
        return (hml == 3'b111) || (hml == 3'b011) || (hml == 3'b001) || (hml == 3'b000);
    endfunction

    function automatic level_t decode_level(input logic [2:0] hml);
        case (hml)
            3'b111:  return LVL_FULL;
            3'b011:  return LVL_MED;
            3'b001:  return LVL_LOW;
            default: return LVL_EMPTY;
        endcase
    endfunction

endpackage

// File: rtl/level_debounce.sv
// Debounce: 2-FF synchroniser followed by a stability filter on a WIDTH-bit vector.
// Latency: 2+DEBOUNCE cycles from a stable input change to dout.
// Backpressure: none; samples every cycle, any change restarts the stability count.
module level_debounce #(
    parameter int WIDTH    = 1,
    parameter int DEBOUNCE = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);
    localparam int CW = $clog2(DEBOUNCE + 1);
    localparam logic [CW-1:0] CNT_SAT = CW'(DEBOUNCE);
    localparam logic [CW-1:0] CNT_THR = CW'(DEBOUNCE - 1);

    logic [WIDTH-1:0] sync1_q, sync1_d;
    logic [WIDTH-1:0] sync2_q, sync2_d;
    logic [WIDTH-1:0] cand_q,  cand_d;
    logic [WIDTH-1:0] out_q,   out_d;
    logic [CW-1:0]    cnt_q,   cnt_d;

    always_comb begin
        sync1_d = din;
        sync2_d = sync1_q;
        cand_d  = cand_q;
        cnt_d   = cnt_q;
        out_d   = out_q;
        if (sync2_q != cand_q) begin
            cand_d = sync2_q;
            cnt_d  = CW'(1);
        end else begin
            if (cnt_q != CNT_SAT) begin
                cnt_d = cnt_q + 1'b1;
            end
            if (cnt_q >= CNT_THR) begin
                out_d = cand_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
            cand_q  <= '0;
            out_q   <= '0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            cand_q  <= cand_d;
            out_q   <= out_d;
            cnt_q   <= cnt_d;
        end
    end

    assign dout = out_q;

endmodule

// File: rtl/irrigation_scheduler.sv
// Multi-zone irrigation controller: tank fill hysteresis, sticky probe errors, round-robin zones; IRR_RAIN_LOCKOUT_EN adds rain_in.
// Latency: 2+DEBOUNCE cycles input-to-decision, all outputs registered one cycle after the decision.
// Backpressure: none; sensors are sampled every cycle and valves follow the FSM directly.
module irrigation_scheduler #(
    parameter int N_ZONES  = 4,
    parameter int DEBOUNCE = 8,
    parameter int MIN_ON   = 1000,
    parameter int MAX_ON   = 60000,
    parameter int GAP      = 16,
    parameter int TIMER_W  = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       lvl_h,
    input  logic                       lvl_m,
    input  logic                       lvl_l,
    input  logic [N_ZONES-1:0]         soil_wet,
    input  logic [N_ZONES-1:0]         soil_dry,
    input  logic                       temp_high,
    input  logic                       err_clr,
`ifdef IRR_RAIN_LOCKOUT_EN
    input  logic                       rain_in,
`endif
    output logic [N_ZONES-1:0]         drip,
    output logic [N_ZONES-1:0]         sprinkler,
    output logic                       inlet_valve,
    output logic                       alarm,
    output logic [1:0]                 level_code,
    output logic                       sensor_err,
    output logic                       busy,
    output logic [$clog2(N_ZONES)-1:0] active_zone
);
    import irrigation_pkg::*;

    localparam int ZW = $clog2(N_ZONES);
    localparam int GW = $clog2(GAP + 1);
    localparam logic [TIMER_W-1:0] MIN_T    = TIMER_W'(MIN_ON);
    localparam logic [TIMER_W-1:0] MAX_T    = TIMER_W'(MAX_ON);
    localparam logic [GW-1:0]      GAP_LAST = GW'(GAP - 1);

    logic [2:0]           lvl_db;
    logic [2*N_ZONES-1:0] soil_db;
    logic                 temp_db;
    logic                 rain_db;
    logic [N_ZONES-1:0]   req;
    level_t               lvl_now;
    logic                 abort;

    level_debounce #(.WIDTH(3), .DEBOUNCE(DEBOUNCE)) u_lvl (
        .clk(clk), .rst(rst), .din({lvl_h, lvl_m, lvl_l}), .dout(lvl_db));
    level_debounce #(.WIDTH(2*N_ZONES), .DEBOUNCE(DEBOUNCE)) u_soil (
        .clk(clk), .rst(rst), .din({soil_dry, soil_wet}), .dout(soil_db));
    level_debounce #(.WIDTH(1), .DEBOUNCE(DEBOUNCE)) u_temp (
        .clk(clk), .rst(rst), .din(temp_high), .dout(temp_db));
`ifdef IRR_RAIN_LOCKOUT_EN
    level_debounce #(.WIDTH(1), .DEBOUNCE(DEBOUNCE)) u_rain (
        .clk(clk), .rst(rst), .din(rain_in), .dout(rain_db));
`else
    assign rain_db = 1'b0;
`endif

    state_t               state_q, state_d;
    mode_t                mode_q, mode_d;
    logic [TIMER_W-1:0]   timer_q, timer_d, timer_inc;
    logic [GW-1:0]        gap_q, gap_d;
    logic [ZW-1:0]        rr_q, rr_d;
    logic [ZW-1:0]        active_zone_q, active_zone_d;
    logic [N_ZONES-1:0]   drip_q, drip_d, sprinkler_q, sprinkler_d;
    logic                 inlet_q, inlet_d, alarm_q, alarm_d;
    logic                 sensor_err_q, sensor_err_d, busy_q, busy_d;
    level_t               level_code_q, level_code_d;
    // err_clr is a single-cycle pulse, so it is synchronised but not debounced.
    logic                 clr_s1_q, clr_s2_q;
    logic [ZW-1:0]        pick, pick_cand;
    logic                 pick_found;
    int                   pick_idx;

    assign req     = soil_db[2*N_ZONES-1:N_ZONES] & ~soil_db[N_ZONES-1:0];
    assign lvl_now = decode_level(lvl_db);

    always_comb begin
        pick       = rr_q;
        pick_cand  = rr_q;
        pick_found = 1'b0;
        pick_idx   = 0;
        for (int k = 1; k <= N_ZONES; k++) begin
            pick_idx = int'(rr_q) + k;
            if (pick_idx >= N_ZONES) begin
                pick_idx = pick_idx - N_ZONES;
            end
            pick_cand = ZW'(pick_idx);
            if (!pick_found && req[pick_cand]) begin
                pick_found = 1'b1;
                pick       = pick_cand;
            end
        end
    end

    always_comb begin
        sensor_err_d  = !level_valid(lvl_db) || (sensor_err_q && !clr_s2_q);
        level_code_d  = sensor_err_d ? LVL_EMPTY : lvl_now;
        alarm_d       = sensor_err_d || (lvl_now == LVL_LOW) || (lvl_now == LVL_EMPTY);
        inlet_d       = inlet_q;
        if (sensor_err_d) begin
            inlet_d = 1'b0;
        end else if ((lvl_now == LVL_LOW) || (lvl_now == LVL_EMPTY)) begin
            inlet_d = 1'b1;
        end else if (lvl_now == LVL_FULL) begin
            inlet_d = 1'b0;
        end

        abort         = (lvl_now == LVL_EMPTY) || sensor_err_d || rain_db;
        state_d       = state_q;
        mode_d        = mode_q;
        timer_d       = timer_q;
        gap_d         = gap_q;
        rr_d          = rr_q;
        active_zone_d = active_zone_q;
        timer_inc     = (timer_q == MAX_T) ? MAX_T : timer_q + 1'b1;

        case (state_q)
            ST_IDLE: begin
                if (pick_found && !abort) begin
                    state_d       = ST_WATER;
                    rr_d          = pick;
                    active_zone_d = pick;
                    timer_d       = '0;
                    mode_d        = (temp_db || lvl_now == LVL_LOW) ? MODE_DRIP : MODE_SPRINKLER;
                end
            end
            ST_WATER: begin
                // timer_inc includes the current cycle, so a run lasts MIN_ON..MAX_ON cycles.
                timer_d = timer_inc;
                if (abort || (timer_inc >= MIN_T && !req[rr_q]) || timer_inc == MAX_T) begin
                    state_d = ST_GAP;
                    gap_d   = '0;
                end else if (mode_q == MODE_SPRINKLER && lvl_now == LVL_LOW) begin
                    mode_d = MODE_DRIP;
                end
            end
            ST_GAP: begin
                if (gap_q == GAP_LAST) begin
                    state_d = ST_IDLE;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        drip_d      = '0;
        sprinkler_d = '0;
        if (state_d == ST_WATER) begin
            if (mode_d == MODE_DRIP) begin
                drip_d[rr_d] = 1'b1;
            end else begin
                sprinkler_d[rr_d] = 1'b1;
            end
        end
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            mode_q        <= MODE_DRIP;
            timer_q       <= '0;
            gap_q         <= '0;
            rr_q          <= ZW'(N_ZONES - 1);
            active_zone_q <= '0;
            drip_q        <= '0;
            sprinkler_q   <= '0;
            inlet_q       <= 1'b0;
            alarm_q       <= 1'b0;
            sensor_err_q  <= 1'b0;
            busy_q        <= 1'b0;
            level_code_q  <= LVL_EMPTY;
            clr_s1_q      <= 1'b0;
            clr_s2_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            mode_q        <= mode_d;
            timer_q       <= timer_d;
            gap_q         <= gap_d;
            rr_q          <= rr_d;
            active_zone_q <= active_zone_d;
            drip_q        <= drip_d;
            sprinkler_q   <= sprinkler_d;
            inlet_q       <= inlet_d;
            alarm_q       <= alarm_d;
            sensor_err_q  <= sensor_err_d;
            busy_q        <= busy_d;
            level_code_q  <= level_code_d;
            clr_s1_q      <= err_clr;
            clr_s2_q      <= clr_s1_q;
        end
    end

    assign drip        = drip_q;
    assign sprinkler   = sprinkler_q;
    assign inlet_valve = inlet_q;
    assign alarm       = alarm_q;
    assign level_code  = level_code_q;
    assign sensor_err  = sensor_err_q;
    assign busy        = busy_q;
    assign active_zone = active_zone_q;

endmodule

// File: tb/tb_irrigation_scheduler.sv
// Directed bench for irrigation_scheduler with a run scoreboard (zone, mode, length).
module tb_irrigation_scheduler;
    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         lvl_h = 1'b0, lvl_m = 1'b0, lvl_l = 1'b0;
    logic [N-1:0] soil_wet = '0, soil_dry = '0;
    logic         temp_high = 1'b0, err_clr = 1'b0;
`ifdef IRR_RAIN_LOCKOUT_EN
    logic         rain_in = 1'b0;
`endif
    logic [N-1:0] drip, sprinkler;
    logic         inlet_valve, alarm, sensor_err, busy;
    logic [1:0]   level_code;
    logic [1:0]   active_zone;

    irrigation_scheduler #(
        .N_ZONES(4), .DEBOUNCE(4), .MIN_ON(8), .MAX_ON(32), .GAP(2), .TIMER_W(16)
    ) dut (
        .clk(clk), .rst(rst), .lvl_h(lvl_h), .lvl_m(lvl_m), .lvl_l(lvl_l),
        .soil_wet(soil_wet), .soil_dry(soil_dry), .temp_high(temp_high), .err_clr(err_clr),
`ifdef IRR_RAIN_LOCKOUT_EN
        .rain_in(rain_in),
`endif
        .drip(drip), .sprinkler(sprinkler), .inlet_valve(inlet_valve), .alarm(alarm),
        .level_code(level_code), .sensor_err(sensor_err), .busy(busy), .active_zone(active_zone)
    );

    always #5 clk = ~clk;

    typedef struct {
        int   zone;
        logic spr;
        int   len;
    } run_t;

    run_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   viol   = 0;

    always @(negedge clk) begin
        if ($countones(drip | sprinkler) > 1) viol++;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "bench did not finish");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic set_lvl(input logic [2:0] v);
        {lvl_h, lvl_m, lvl_l} = v;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        ticks(3);
        rst = 1'b0;
        ticks(10);
    endtask

    task automatic wait_valve(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            if ((drip | sprinkler) != '0) ok = 1'b1;
            else tick();
        end
        check("valve_wait", {31'd0, ok}, 32'd1);
    endtask

    function automatic int onehot_idx(input logic [N-1:0] v);
        int r = -1;
        for (int i = 0; i < N; i++) if (v[i]) r = i;
        return r;
    endfunction

    // Waits for a run, applies the stimulus that should end it, and scores it against the queue.
    task automatic measure_run(input logic [N-1:0] drop, input logic [N-1:0] restore,
                               input bit lvl_on, input logic [2:0] lvl_v);
        run_t e;
        bit   ok;
        int   len;
        int   z;
        logic spr;
        wait_valve(ok);
        z   = onehot_idx(drip | sprinkler);
        spr = (sprinkler != '0);
        check("sb_nonempty", {31'd0, exp_q.size() != 0}, 32'd1);
        if (exp_q.size() != 0) e = exp_q.pop_front();
        else e = '{zone: -1, spr: 1'b0, len: 0};
        soil_dry = soil_dry & ~drop;
        if (lvl_on) set_lvl(lvl_v);
        len = 0;
        while ((drip | sprinkler) != '0 && len < 200) begin
            len++;
            tick();
        end
        soil_dry = soil_dry | restore;
        check("run_zone", z, e.zone);
        check("run_mode", {31'd0, spr}, {31'd0, e.spr});
        check("run_len", len, e.len);
        check("run_active_zone", {30'd0, active_zone}, e.zone);
    endtask

    initial begin
        bit ok;

        // Reset state
        ticks(3);
        check("rst_outputs", {16'd0, drip, sprinkler, inlet_valve, alarm, level_code,
                              sensor_err, busy, active_zone}, 32'd0);
        rst = 1'b0;
        ticks(10);

        // Tank level walk with fill hysteresis
        check("t1_empty_code", level_code, 0);
        check("t1_empty_inlet", inlet_valve, 1);
        check("t1_empty_alarm", alarm, 1);
        check("t1_err", sensor_err, 0);
        set_lvl(3'b001); ticks(10);
        check("t1_low_code", level_code, 1);
        check("t1_low_inlet", inlet_valve, 1);
        check("t1_low_alarm", alarm, 1);
        set_lvl(3'b011); ticks(10);
        check("t1_med_code", level_code, 2);
        check("t1_med_inlet", inlet_valve, 1);
        check("t1_med_alarm", alarm, 0);
        set_lvl(3'b111); ticks(10);
        check("t1_full_code", level_code, 3);
        check("t1_full_inlet", inlet_valve, 0);
        set_lvl(3'b011); ticks(10);
        check("t1_med2_inlet", inlet_valve, 0);
        check("t1_idle", busy, 0);

        // Round robin 1,3,1, each held to MIN_ON after its dry probe drops
        exp_q.push_back('{zone: 1, spr: 1'b1, len: 8});
        exp_q.push_back('{zone: 3, spr: 1'b1, len: 8});
        exp_q.push_back('{zone: 1, spr: 1'b1, len: 8});
        soil_dry = 4'b1010;
        measure_run(4'b0010, 4'b0010, 1'b0, 3'b000);
        measure_run(4'b1000, 4'b1000, 1'b0, 3'b000);
        measure_run(4'b1010, 4'b0000, 1'b0, 3'b000);
        ticks(10);
        check("t2_idle", busy, 0);
        check("t2_last_zone", active_zone, 1);

        // Zone 0 held dry: MAX_ON cut-off, busy through GAP, zone 0 restarts
        soil_dry = '0;
        do_reset();
        exp_q.push_back('{zone: 0, spr: 1'b1, len: 32});
        exp_q.push_back('{zone: 0, spr: 1'b1, len: 8});
        soil_dry = 4'b0001;
        measure_run(4'b0000, 4'b0000, 1'b0, 3'b000);
        check("t3_gap_busy1", busy, 1);
        tick();
        check("t3_gap_busy2", busy, 1);
        measure_run(4'b0001, 4'b0000, 1'b0, 3'b000);
        ticks(12);
        check("t3_idle", busy, 0);

        // Sprinkler downgrades to drip at LOW, EMPTY aborts
        do_reset();
        soil_dry = 4'b0001;
        wait_valve(ok);
        check("t4_spr_start", sprinkler, 4'b0001);
        set_lvl(3'b001);
        ticks(6);
        check("t4_pre_downgrade", sprinkler, 4'b0001);
        tick();
        check("t4_drip", drip, 4'b0001);
        check("t4_spr_off", sprinkler, 4'b0000);
        set_lvl(3'b000);
        ticks(6);
        check("t4_pre_abort", drip, 4'b0001);
        tick();
        check("t4_abort_drip", drip, 4'b0000);
        check("t4_abort_gap", busy, 1);
        check("t4_abort_alarm", alarm, 1);
        ticks(10);
        check("t4_empty_hold", busy, 0);
        exp_q.push_back('{zone: 0, spr: 1'b1, len: 7});
        set_lvl(3'b011);
        measure_run(4'b0000, 4'b0000, 1'b1, 3'b000);
        soil_dry = '0;
        set_lvl(3'b011);
        ticks(10);

        // Invalid probe code, sticky error, clear
        do_reset();
        soil_dry = 4'b0001;
        set_lvl(3'b101);
        ticks(7);
        check("t5_err", sensor_err, 1);
        check("t5_alarm", alarm, 1);
        check("t5_code", level_code, 0);
        check("t5_inlet", inlet_valve, 0);
        check("t5_valves", {drip, sprinkler}, 0);
        check("t5_busy", busy, 0);
        err_clr = 1'b1; tick(); err_clr = 1'b0;
        ticks(5);
        check("t5_clr_ignored", sensor_err, 1);
        set_lvl(3'b111);
        ticks(8);
        check("t5_sticky", sensor_err, 1);
        err_clr = 1'b1; tick(); err_clr = 1'b0;
        ticks(4);
        check("t5_cleared", sensor_err, 0);
        check("t5_full_code", level_code, 3);
        check("t5_alarm_off", alarm, 0);

        // Reset in the middle of a run
        wait_valve(ok);
        check("t6_running", sprinkler, 4'b0001);
        rst = 1'b1;
        tick();
        check("t6_rst", {16'd0, drip, sprinkler, inlet_valve, alarm, level_code,
                         sensor_err, busy, active_zone}, 32'd0);
        rst = 1'b0;
        soil_dry = '0;
        ticks(10);

`ifdef IRR_RAIN_LOCKOUT_EN
        rain_in  = 1'b1;
        soil_dry = 4'b0001;
        ticks(30);
        check("t7_rain_valves", {drip, sprinkler}, 0);
        check("t7_rain_busy", busy, 0);
        rain_in = 1'b0;
        wait_valve(ok);
        soil_dry = '0;
        ticks(50);
`endif

        check("onehot_violations", viol, 0);
        check("sb_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
